// File: rtl/chip8_draw_engine.sv
// CHIP-8 DXYN / 00E0 sequencer feeding the GPU framebuffer write port.
// Fetches sprite rows, reads back the covered framebuffer bytes, XORs them and reports VF.
module chip8_draw_engine (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        cls,
    input  logic [7:0]  x_in,
    input  logic [7:0]  y_in,
    input  logic [3:0]  n_in,
    input  logic [11:0] i_in,
    output logic        busy,
    output logic        done,
    output logic        collision,
    output logic [11:0] mem_addr,
    output logic        mem_rd,
    input  logic [7:0]  mem_rdata,
    output logic        fb_rd,
    output logic [5:0]  fb_rd_x,
    output logic [4:0]  fb_rd_y,
    input  logic [7:0]  fb_rdata,
    output logic [5:0]  fb_x,
    output logic [4:0]  fb_y,
    output logic [7:0]  fb_sprite,
    output logic        fb_we
);

    typedef enum logic [2:0] {IDLE, FETCH, FBRD, WRITE, CLR, DONE} state_t;

    state_t      state, state_n;
    logic [5:0]  x_q, x_n;
    logic [4:0]  y_q, y_n;
    logic [3:0]  n_q, n_n;
    logic [11:0] i_q, i_n;
    logic [3:0]  r_q, r_n;
    logic [7:0]  c_q, c_n;
    logic [7:0]  s_q, s_rev;
    logic        acc_q, acc_n;
    logic        hit;
    logic [4:0]  row_y;
    logic [11:0] addr_n;
    logic        unused_bits;

    assign unused_bits = ^{x_in[7:6], y_in[7:5]};

    // Memory MSB is the leftmost pixel, which the GPU expects in sprite bit 0.
    assign s_rev = {mem_rdata[0], mem_rdata[1], mem_rdata[2], mem_rdata[3],
                    mem_rdata[4], mem_rdata[5], mem_rdata[6], mem_rdata[7]};
    assign hit   = |(fb_rdata & s_q);

    always_comb begin
        state_n = state;
        x_n     = x_q;
        y_n     = y_q;
        n_n     = n_q;
        i_n     = i_q;
        r_n     = r_q;
        c_n     = c_q;
        acc_n   = acc_q;
        case (state)
            IDLE: begin
                if (cls || start) begin
                    x_n   = x_in[5:0];
                    y_n   = y_in[4:0];
                    n_n   = n_in;
                    i_n   = i_in;
                    r_n   = '0;
                    c_n   = '0;
                    acc_n = 1'b0;
                    if (cls)
                        state_n = CLR;
                    else if (n_in == 4'd0)
                        state_n = DONE;
                    else
                        state_n = FETCH;
                end
            end
            FETCH: state_n = FBRD;
            FBRD:  state_n = WRITE;
            WRITE: begin
                acc_n = acc_q | hit;
                if (r_q == n_q - 4'd1) begin
                    state_n = DONE;
                end else begin
                    r_n     = r_q + 4'd1;
                    state_n = FETCH;
                end
            end
            CLR: begin
                if (c_q == 8'hFF)
                    state_n = DONE;
                else
                    c_n = c_q + 8'd1;
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
        row_y  = y_n + {1'b0, r_n};
        addr_n = i_n + {8'b0, r_n};
    end

    always_comb begin
        fb_sprite = '0;
        if (state == WRITE)
            fb_sprite = fb_rdata ^ s_q;
    end

    // Outputs are registered from next-state values so each strobe lines up with its state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            x_q       <= '0;
            y_q       <= '0;
            n_q       <= '0;
            i_q       <= '0;
            r_q       <= '0;
            c_q       <= '0;
            s_q       <= '0;
            acc_q     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            collision <= 1'b0;
            mem_rd    <= 1'b0;
            mem_addr  <= '0;
            fb_rd     <= 1'b0;
            fb_rd_x   <= '0;
            fb_rd_y   <= '0;
            fb_we     <= 1'b0;
            fb_x      <= '0;
            fb_y      <= '0;
        end else begin
            state    <= state_n;
            x_q      <= x_n;
            y_q      <= y_n;
            n_q      <= n_n;
            i_q      <= i_n;
            r_q      <= r_n;
            c_q      <= c_n;
            acc_q    <= acc_n;
            if (state == FBRD)
                s_q <= s_rev;
            busy     <= state_n inside {FETCH, FBRD, WRITE, CLR};
            done     <= (state_n == DONE);
            if (state_n == DONE)
                collision <= acc_n;
            mem_rd   <= (state_n == FETCH);
            mem_addr <= addr_n;
            fb_rd    <= (state_n == FBRD);
            fb_rd_x  <= x_n;
            fb_rd_y  <= row_y;
            fb_we    <= state_n inside {WRITE, CLR};
            fb_x     <= (state_n == CLR) ? {c_n[2:0], 3'b000} : x_n;
            fb_y     <= (state_n == CLR) ? c_n[7:3] : row_y;
        end
    end

endmodule

// File: tb/tb_chip8_draw_engine.sv
// Scoreboard bench for chip8_draw_engine: sprite memory and framebuffer models,
// expected strobes queued at issue time and checked by an independent monitor.
module tb_chip8_draw_engine;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        cls = 1'b0;
    logic [7:0]  x_in = '0;
    logic [7:0]  y_in = '0;
    logic [3:0]  n_in = '0;
    logic [11:0] i_in = '0;
    logic        busy, done, collision;
    logic [11:0] mem_addr;
    logic        mem_rd;
    logic [7:0]  mem_rdata = '0;
    logic        fb_rd;
    logic [5:0]  fb_rd_x;
    logic [4:0]  fb_rd_y;
    logic [7:0]  fb_rdata = '0;
    logic [5:0]  fb_x;
    logic [4:0]  fb_y;
    logic [7:0]  fb_sprite;
    logic        fb_we;

    chip8_draw_engine dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cls(cls),
        .x_in(x_in), .y_in(y_in), .n_in(n_in), .i_in(i_in),
        .busy(busy), .done(done), .collision(collision),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata),
        .fb_rd(fb_rd), .fb_rd_x(fb_rd_x), .fb_rd_y(fb_rd_y), .fb_rdata(fb_rdata),
        .fb_x(fb_x), .fb_y(fb_y), .fb_sprite(fb_sprite), .fb_we(fb_we)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        bit coll;
    } done_t;

    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    logic [11:0] mem_q[$];
    logic [18:0] wr_q[$];
    done_t       done_q[$];
    logic [7:0]  mem [4096];
    logic        fbm [32][64];

    always @(posedge clk) cyc <= cyc + 1;

    // Sprite memory and framebuffer: one-cycle read latency, write on we.
    always @(posedge clk) begin
        logic [7:0] tmp;
        tmp = '0;
        if (mem_rd) mem_rdata <= mem[mem_addr];
        if (fb_rd) begin
            for (int k = 0; k < 8; k++) tmp[k] = fbm[fb_rd_y][6'(fb_rd_x + k)];
            fb_rdata <= tmp;
        end
        if (fb_we)
            for (int k = 0; k < 8; k++) fbm[fb_y][6'(fb_x + k)] <= fb_sprite[k];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a strobe or completion.
    always @(negedge clk) begin
        done_t e;
        if (mem_rd || fb_rd || fb_we)
            chk("strobe_excl", 32'(mem_rd) + 32'(fb_rd) + 32'(fb_we), 1);
        if (mem_rd) begin
            if (mem_q.size() == 0) chk("mem_rd_unexp", mem_rd, 0);
            else chk("mem_addr", mem_addr, mem_q.pop_front());
        end
        if (fb_we) begin
            if (wr_q.size() == 0) chk("fb_we_unexp", fb_we, 0);
            else chk("fb_write{y,x,d}", {fb_y, fb_x, fb_sprite}, wr_q.pop_front());
        end
        if (done) begin
            if (done_q.size() == 0) begin
                chk("done_unexp", done, 0);
            end else begin
                e = done_q.pop_front();
                chk("done_cycle", cyc, e.cyc);
                chk("collision", collision, e.coll);
            end
        end
    end

    task automatic issue(input bit do_start, input bit do_cls, input logic [7:0] x,
                         input logic [7:0] y, input logic [3:0] n, input logic [11:0] i,
                         input int lat, input bit exp_coll, input bit push_done,
                         input bit exp_busy);
        @(negedge clk);
        if (push_done) done_q.push_back('{cyc + lat, exp_coll});
        x_in = x; y_in = y; n_in = n; i_in = i;
        start = do_start;
        cls = do_cls;
        @(negedge clk);
        start = 1'b0;
        cls = 1'b0;
        chk("busy_t1", busy, exp_busy);
    endtask

    task automatic wait_idle();
        int k = 0;
        while (done_q.size() != 0 && k < 400) begin
            @(negedge clk);
            k++;
        end
        if (done_q.size() != 0) begin
            chk("done_timeout", done_q.size(), 0);
            done_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic draw_font(input bit second);
        logic [7:0] rows [5];
        rows = '{8'h0F, 8'h09, 8'h09, 8'h09, 8'h0F};
        for (int r = 0; r < 5; r++) begin
            mem_q.push_back(12'h050 + 12'(r));
            wr_q.push_back({5'(r), 6'd0, second ? 8'h00 : rows[r]});
        end
        issue(1, 0, 8'd0, 8'd0, 4'd5, 12'h050, 16, second, 1, 1);
        wait_idle();
    endtask

    task automatic draw_wrap(input bit second);
        mem_q.push_back(12'hFFF);
        mem_q.push_back(12'h000);
        wr_q.push_back({5'd31, 6'd62, second ? 8'h00 : 8'h01});
        wr_q.push_back({5'd0, 6'd62, second ? 8'h00 : 8'h80});
        issue(1, 0, 8'd62, 8'd31, 4'd2, 12'hFFF, 7, second, 1, 1);
        wait_idle();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_flags"}, {busy, done, collision, mem_rd, fb_rd, fb_we}, 0);
        chk({tag, "_rdaddr"}, {mem_addr, fb_rd_x, fb_rd_y}, 0);
        chk({tag, "_wraddr"}, {fb_x, fb_y, fb_sprite}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int a = 0; a < 4096; a++) mem[a] = '0;
        for (int y = 0; y < 32; y++)
            for (int x = 0; x < 64; x++) fbm[y][x] = 1'b0;
        mem[12'h050] = 8'hF0; mem[12'h051] = 8'h90; mem[12'h052] = 8'h90;
        mem[12'h053] = 8'h90; mem[12'h054] = 8'hF0;
        mem[12'hFFF] = 8'h80; mem[12'h000] = 8'h01;
        mem[12'h100] = 8'hA5; mem[12'h101] = 8'h3C; mem[12'h102] = 8'h77;

        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        draw_font(0);
        draw_font(1);

        // n=0 right after a collision: completes next cycle with VF cleared.
        issue(1, 0, 8'd3, 8'd3, 4'd0, 12'h050, 1, 0, 1, 0);
        wait_idle();

        draw_wrap(0);
        draw_wrap(1);

        // cls and start together: clear wins; a start during the clear is dropped.
        for (int c = 0; c < 256; c++) begin
            logic [7:0] cc;
            cc = 8'(c);
            wr_q.push_back({cc[7:3], cc[2:0], 3'b000, 8'h00});
        end
        issue(1, 1, 8'd0, 8'd0, 4'd3, 12'h050, 257, 0, 1, 1);
        repeat (50) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        repeat (10) @(negedge clk);

        draw_font(0);
        draw_font(1);

        // Abort a 10-row draw during row 2's framebuffer read.
        mem_q.push_back(12'h100);
        mem_q.push_back(12'h101);
        mem_q.push_back(12'h102);
        wr_q.push_back({5'd10, 6'd20, 8'hA5});
        wr_q.push_back({5'd11, 6'd20, 8'h3C});
        issue(1, 0, 8'd20, 8'd10, 4'd10, 12'h100, 0, 0, 0, 1);
        repeat (7) @(negedge clk);
        chk("pre_reset_fb_rd", fb_rd, 1);
        #1 rst_n = 1'b0;
        #1 check_reset_outputs("abort");
        chk("abort_mem_left", mem_q.size(), 0);
        chk("abort_wr_left", wr_q.size(), 0);
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Partial row 0 is still on screen; erasing it collides.
        mem_q.push_back(12'h100);
        wr_q.push_back({5'd10, 6'd20, 8'h00});
        issue(1, 0, 8'd20, 8'd10, 4'd1, 12'h100, 4, 1, 1, 1);
        wait_idle();
        repeat (5) @(negedge clk);

        chk("end_mem_q", mem_q.size(), 0);
        chk("end_wr_q", wr_q.size(), 0);
        chk("end_done_q", done_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/chip8_draw_engine.md
# chip8_draw_engine

Sequencer for CHIP-8 DXYN (sprite draw) and 00E0 (clear screen), sitting directly upstream of the GPU framebuffer write port. On a command it fetches sprite bytes from program memory, reads back the covered framebuffer bytes, XORs them, writes each result row through the GPU's `x_addr`/`y_addr`/`sprite`/`we_stb` interface, and reports the VF collision flag to the CPU core.

## Interface
- No parameters; geometry is fixed at 64x32, 8-pixel sprite rows, 12-bit address space.
- `clk` in 1: system clock (same clock as the GPU write port).
- `rst_n` in 1: asynchronous active-low reset.
- `start` in 1: one-cycle DXYN command strobe, honoured only in IDLE.
- `cls` in 1: one-cycle 00E0 command strobe, honoured only in IDLE; wins over `start`.
- `x_in` in 8: Vx value; bits [5:0] are used (mod 64).
- `y_in` in 8: Vy value; bits [4:0] are used (mod 32).
- `n_in` in 4: sprite height in rows.
- `i_in` in 12: I register, address of the first sprite byte.
- `busy` out 1: high from the cycle after acceptance until `done`.
- `done` out 1: one-cycle completion pulse.
- `collision` out 1: VF result; updated with `done`, held until the next accepted command.
- `mem_addr` out 12: sprite byte address.
- `mem_rd` out 1: read strobe; `mem_rdata` is valid exactly one cycle later.
- `mem_rdata` in 8: sprite byte, MSB = leftmost pixel.
- `fb_rd` out 1: framebuffer read strobe; `fb_rdata` is valid exactly one cycle later.
- `fb_rd_x` out 6: read start column.
- `fb_rd_y` out 5: read row.
- `fb_rdata` in 8: bit k = pixel at column (`fb_rd_x`+k) mod 64.
- `fb_x` out 6: GPU `x_addr`.
- `fb_y` out 5: GPU `y_addr`.
- `fb_sprite` out 8: GPU `sprite`; bit k lands at column `fb_x`+k.
- `fb_we` out 1: GPU `we_stb`, one cycle per row written.

## Operation
- States: IDLE, FETCH, FBRD, WRITE, CLR, DONE.
- In IDLE, `cls` or `start` latches `x_in[5:0]`, `y_in[4:0]`, `n_in`, and `i_in`, and clears the collision accumulator. A row counter r is reset to 0.
  - `cls` takes the engine to CLR.
  - `start` with n=0 goes to DONE with collision 0.
  - `start` with n>0 goes to FETCH.
- FETCH:
  - `mem_rd`=1, `mem_addr` = (I + r) mod 4096.
  - Next state FBRD.
- FBRD:
  - Capture s = bit-reverse(`mem_rdata`), so memory MSB maps to `fb_sprite[0]` (leftmost).
  - `fb_rd`=1, `fb_rd_x` = X, `fb_rd_y` = (Y + r) mod 32.
  - Next state WRITE.
- WRITE:
  - `fb_we`=1, `fb_x` = X, `fb_y` = (Y + r) mod 32, `fb_sprite` = `fb_rdata` XOR s.
  - Accumulator |= OR-reduce(`fb_rdata` AND s).
  - If r = n-1, go to DONE; otherwise r++ and go to FETCH.
- Wrap-around: both X+k and Y+r wrap (the GPU wraps X natively). There is no clipping.
- CLR:
  - Writes `fb_sprite`=0 with `fb_we`=1 every cycle, `fb_y` = c[7:3], `fb_x` = {c[2:0], 3'b000}, for c = 0..255. This is 256 cycles.
  - After c=255, go to DONE. collision is set to 0.
- DONE: `done`=1, `collision` = accumulator, `busy`=0. Next state IDLE.
- `start`/`cls` while not IDLE: ignored; no queueing.
- Strobes are exclusive: at most one of `mem_rd`, `fb_rd`, `fb_we` is high in any cycle.
- Reset value of every output is 0, and the state is IDLE. Reset mid-command aborts immediately with no further strobes; a partially drawn sprite stays in the framebuffer.

## Timing
- Command accepted at edge t: `busy` rises at t+1.
- DXYN with n>0:
  - Row r occupies cycles t+1+3r (FETCH), t+2+3r (FBRD), t+3+3r (WRITE).
  - `done` at t+1+3n. Total latency 3n+1 cycles; a 15-row sprite takes 46 cycles.
- DXYN with n=0: `done` at t+1.
- CLS: writes on t+1..t+256, `done` at t+257.
- `collision` changes only in the `done` cycle, or to 0 on reset.
- The earliest next acceptance is the cycle after `done`.
- Outputs are registered, except that `fb_sprite` in WRITE may be combinational from `fb_rdata`. Address and data outputs are don't-care whenever their strobe is low.

## Test plan
- Draw on empty screen: X=0, Y=0, n=5, I=0x050, memory `F0 90 90 90 F0`. Expect `mem_addr` 0x050..0x054 and `fb_sprite` rows 0x0F, 0x09, 0x09, 0x09, 0x0F. `done` at t+16, `collision`=0.
- Redraw same sprite: writes all 0x00, `collision`=1.
- Wrap: X=62, Y=31, n=2, I=0xFFF, bytes `80 01`.
  - Addresses 0xFFF then 0x000.
  - Rows y=31 then y=0, `fb_x`=62.
  - `fb_sprite` 0x01 then 0x80.
- CLS: exactly 256 `fb_we` pulses, all data 0, covering every (y, x-block) once. `done` at t+257, `collision`=0.
- Command hazards:
  - `start` and `cls` in the same cycle: CLS runs.
  - `start` pulsed during CLS: ignored; no extra `mem_rd` after `done`.
  - n=0: `done` at t+1, no strobes.
- Reset: deassert `rst_n` during row 2 of a 10-row draw. All outputs go to 0 asynchronously, no further strobes, `collision`=0. A new `start` after release works normally.
